// File: rtl/param_reservation_station.sv
// param_reservation_station: parametrised Tomasulo reservation station.
// Holds dispatched instructions until both operands are valid, snoops the CDB
// for pending operands and issues ready entries over a valid/ready handshake.
// Optional feature macro RS_AGE_ORDER_EN: oldest-ready issue via an age matrix.
// Default build (macro undefined): lowest-index ready entry issues, no age state.
module param_reservation_station #(
   parameter int DATA_W   = 8,
   parameter int TAG_W    = 3,
   parameter int DEPTH    = 4,
   parameter int TAG_BASE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   output logic [TAG_W-1:0]           disp_tag,
   input  logic [DATA_W-1:0]          disp_op1,
   input  logic [DATA_W-1:0]          disp_op2,
   input  logic                       disp_op1_vbit,
   input  logic                       disp_op2_vbit,
   input  logic [TAG_W-1:0]           disp_op1_tag,
   input  logic [TAG_W-1:0]           disp_op2_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_data,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [DATA_W-1:0]          iss_op1,
   output logic [DATA_W-1:0]          iss_op2,
   output logic [TAG_W-1:0]           iss_tag,
   output logic [$clog2(DEPTH+1)-1:0] rs_count,
   output logic                       rs_full
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              busy;
      logic              op1_vbit;
      logic              op2_vbit;
      logic [TAG_W-1:0]  op1_tag;
      logic [TAG_W-1:0]  op2_tag;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] ready;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [CNT_W-1:0] count;
   logic             do_disp;
   logic             do_iss;

   // Occupancy, ready vector and lowest-index free entry for allocation.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      count      = '0;
      free_found = 1'b0;
      free_idx   = '0;
      ready      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count    = count + CNT_W'(ent_q[i].busy);
         ready[i] = ent_q[i].busy && ent_q[i].op1_vbit && ent_q[i].op2_vbit;
         if (!ent_q[i].busy && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

`ifdef RS_AGE_ORDER_EN
   // age_q[i][j] = 1 means entry i was dispatched before entry j.
   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] age_d [DEPTH];
   logic             older_ready;

   // Select the oldest ready entry: one with no older ready entry.
   always_comb begin
      sel_found   = 1'b0;
      sel_idx     = '0;
      older_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         older_ready = 1'b0;
         for (int j = 0; j < DEPTH; j++)
            if (ready[j] && age_q[j][i]) older_ready = 1'b1;
         if (ready[i] && !older_ready && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // New entry is younger than every busy entry; freed entries leave the matrix.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
      if (do_disp) begin
         for (int j = 0; j < DEPTH; j++) begin
            age_d[j][free_idx] = ent_q[j].busy;
            age_d[free_idx][j] = 1'b0;
         end
      end
      if (do_iss) begin
         for (int j = 0; j < DEPTH; j++) begin
            age_d[sel_idx][j] = 1'b0;
            age_d[j][sel_idx] = 1'b0;
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
      end
   end

   // Age matrix register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
      end
   end
`else
   // Select the lowest-index ready entry.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end
`endif

   assign rs_count   = count;
   assign rs_full    = (count == CNT_W'(DEPTH));
   assign disp_ready = !rs_full;
   assign disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
   assign iss_valid  = sel_found;
   assign iss_op1    = iss_valid ? ent_q[sel_idx].op1 : '0;
   assign iss_op2    = iss_valid ? ent_q[sel_idx].op2 : '0;
   assign iss_tag    = iss_valid ? TAG_W'(TAG_BASE) + TAG_W'(sel_idx) : '0;
   assign do_disp    = disp_valid && disp_ready;
   assign do_iss     = iss_valid && iss_ready;

   // Next entry state: CDB snoop, issue release, dispatch with CDB bypass, flush.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (cdb_valid && ent_q[i].busy) begin
            if (!ent_q[i].op1_vbit && ent_q[i].op1_tag == cdb_tag) begin
               ent_d[i].op1      = cdb_data;
               ent_d[i].op1_vbit = 1'b1;
            end
            if (!ent_q[i].op2_vbit && ent_q[i].op2_tag == cdb_tag) begin
               ent_d[i].op2      = cdb_data;
               ent_d[i].op2_vbit = 1'b1;
            end
         end
      end
      if (do_iss) ent_d[sel_idx].busy = 1'b0;
      if (do_disp) begin
         ent_d[free_idx].busy     = 1'b1;
         ent_d[free_idx].op1      = disp_op1;
         ent_d[free_idx].op1_vbit = disp_op1_vbit;
         ent_d[free_idx].op1_tag  = disp_op1_tag;
         ent_d[free_idx].op2      = disp_op2;
         ent_d[free_idx].op2_vbit = disp_op2_vbit;
         ent_d[free_idx].op2_tag  = disp_op2_tag;
         // Same-cycle broadcast of a pending operand's producer must not be missed.
         if (cdb_valid && !disp_op1_vbit && disp_op1_tag == cdb_tag) begin
            ent_d[free_idx].op1      = cdb_data;
            ent_d[free_idx].op1_vbit = 1'b1;
         end
         if (cdb_valid && !disp_op2_vbit && disp_op2_tag == cdb_tag) begin
            ent_d[free_idx].op2      = cdb_data;
            ent_d[free_idx].op2_vbit = 1'b1;
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      end
   end

   // Entry array register.
   // NOTE: the entry array is control state (busy bits), so every entry is reset, not just a valid flag.
   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end
endmodule

// File: tb/tb_param_reservation_station.sv
// Self-checking bench for param_reservation_station (default parameters).
// Expected issue records are queued as stimulus is driven and compared on issue.
module tb_param_reservation_station;
   localparam int DATA_W = 8;
   localparam int TAG_W  = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              disp_valid;
   logic              disp_ready;
   logic [TAG_W-1:0]  disp_tag;
   logic [DATA_W-1:0] disp_op1;
   logic [DATA_W-1:0] disp_op2;
   logic              disp_op1_vbit;
   logic              disp_op2_vbit;
   logic [TAG_W-1:0]  disp_op1_tag;
   logic [TAG_W-1:0]  disp_op2_tag;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              iss_valid;
   logic              iss_ready;
   logic [DATA_W-1:0] iss_op1;
   logic [DATA_W-1:0] iss_op2;
   logic [TAG_W-1:0]  iss_tag;
   logic [CNT_W-1:0]  rs_count;
   logic              rs_full;

   typedef struct {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [TAG_W-1:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   param_reservation_station #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TAG_BASE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
      .disp_op1(disp_op1), .disp_op2(disp_op2),
      .disp_op1_vbit(disp_op1_vbit), .disp_op2_vbit(disp_op2_vbit),
      .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_tag(iss_tag),
      .rs_count(rs_count), .rs_full(rs_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [7:0] op1, input logic v1, input logic [2:0] t1,
                           input logic [7:0] op2, input logic v2, input logic [2:0] t2);
      disp_valid    = 1'b1;
      disp_op1      = op1;
      disp_op1_vbit = v1;
      disp_op1_tag  = t1;
      disp_op2      = op2;
      disp_op2_vbit = v2;
      disp_op2_tag  = t2;
   endtask

   task automatic dispatch(input logic [7:0] op1, input logic v1, input logic [2:0] t1,
                           input logic [7:0] op2, input logic v2, input logic [2:0] t2);
      set_disp(op1, v1, t1, op2, v2, t2);
      step();
      disp_valid = 1'b0;
   endtask

   task automatic broadcast(input logic [2:0] tag, input logic [7:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
      step();
      cdb_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] op1, input logic [7:0] op2, input logic [2:0] tag);
      exp_t e;
      e.op1 = op1;
      e.op2 = op2;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Compare the offered issue against the scoreboard head, then accept it.
   task automatic issue_one(input string name);
      exp_t e;
      check({name, "_valid"}, 32'(iss_valid), 1);
      check({name, "_sb_avail"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({name, "_op1"}, 32'(iss_op1), 32'(e.op1));
         check({name, "_op2"}, 32'(iss_op2), 32'(e.op2));
         check({name, "_tag"}, 32'(iss_tag), 32'(e.tag));
      end
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
   endtask

   task automatic check_empty(input string name);
      check({name, "_count"},      32'(rs_count),   0);
      check({name, "_iss_valid"},  32'(iss_valid),  0);
      check({name, "_disp_tag"},   32'(disp_tag),   1);
      check({name, "_disp_ready"}, 32'(disp_ready), 1);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0; cdb_valid = 1'b0;
      disp_op1 = '0; disp_op2 = '0; disp_op1_vbit = 1'b0; disp_op2_vbit = 1'b0;
      disp_op1_tag = '0; disp_op2_tag = '0; cdb_tag = '0; cdb_data = '0;
      step();
      step();
      // Reset state
      check("rst_disp_ready", 32'(disp_ready), 1);
      check("rst_disp_tag",   32'(disp_tag),   1);
      check("rst_iss_valid",  32'(iss_valid),  0);
      check("rst_iss_op1",    32'(iss_op1),    0);
      check("rst_iss_op2",    32'(iss_op2),    0);
      check("rst_iss_tag",    32'(iss_tag),    0);
      check("rst_count",      32'(rs_count),   0);
      check("rst_full",       32'(rs_full),    0);
      rst_n = 1'b1;
      step();

      // Basic dispatch with both operands valid, issue one cycle later
      check("t1_disp_tag", 32'(disp_tag), 1);
      dispatch(8'h12, 1'b1, 3'd0, 8'h34, 1'b1, 3'd0);
      push(8'h12, 8'h34, 3'd1);
      check("t1_count1", 32'(rs_count), 1);
      issue_one("t1_iss");
      check_empty("t1_after");
      // iss_ready with an empty station has no effect
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      check_empty("t1_idle_ready");

      // Pending op1 woken by a later CDB broadcast; non-matching tag ignored
      dispatch(8'h00, 1'b0, 3'd5, 8'h07, 1'b1, 3'd0);
      check("t2_pending", 32'(iss_valid), 0);
      broadcast(3'd6, 8'h55);
      check("t2_wrong_tag", 32'(iss_valid), 0);
      broadcast(3'd5, 8'hAA);
      push(8'hAA, 8'h07, 3'd1);
      issue_one("t2_iss");
      check_empty("t2_after");

      // Dispatch and matching broadcast in the same cycle
      cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h3C;
      dispatch(8'h11, 1'b1, 3'd0, 8'h00, 1'b0, 3'd6);
      cdb_valid = 1'b0;
      push(8'h11, 8'h3C, 3'd1);
      issue_one("t3_iss");
      check_empty("t3_after");

      // Fill the station, overflow attempt, issue while full with dispatch pending
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("t4_disp_tag%0d", i), 32'(disp_tag), i + 1);
         dispatch(8'(8'h21 + i), 1'b1, 3'd0, 8'(8'h31 + i), 1'b1, 3'd0);
      end
      check("t4_full",       32'(rs_full),    1);
      check("t4_disp_ready", 32'(disp_ready), 0);
      check("t4_count",      32'(rs_count),   4);
      dispatch(8'h99, 1'b1, 3'd0, 8'h99, 1'b1, 3'd0);
      check("t4_overflow_count", 32'(rs_count), 4);
      push(8'h21, 8'h31, 3'd1);
      set_disp(8'h25, 1'b1, 3'd0, 8'h35, 1'b1, 3'd0);
      issue_one("t4_iss_full");
      disp_valid = 1'b0;
      check("t4_count_after_iss", 32'(rs_count),   3);
      check("t4_reuse_tag",       32'(disp_tag),   1);
      check("t4_ready_again",     32'(disp_ready), 1);
      dispatch(8'h25, 1'b1, 3'd0, 8'h35, 1'b1, 3'd0);
      check("t4_refill_count", 32'(rs_count), 4);
`ifdef RS_AGE_ORDER_EN
      push(8'h22, 8'h32, 3'd2);
      push(8'h23, 8'h33, 3'd3);
      push(8'h24, 8'h34, 3'd4);
      push(8'h25, 8'h35, 3'd1);
`else
      push(8'h25, 8'h35, 3'd1);
      push(8'h22, 8'h32, 3'd2);
      push(8'h23, 8'h33, 3'd3);
      push(8'h24, 8'h34, 3'd4);
`endif
      for (int i = 0; i < DEPTH; i++) issue_one($sformatf("t4_drain%0d", i));
      check_empty("t4_after");

      // Selection order: entry 0 re-dispatched after entry 1, both woken
      dispatch(8'h41, 1'b1, 3'd0, 8'h51, 1'b1, 3'd0);
      dispatch(8'h00, 1'b0, 3'd6, 8'h52, 1'b1, 3'd0);
      push(8'h41, 8'h51, 3'd1);
      issue_one("t5_first");
      check("t5_disp_tag", 32'(disp_tag), 1);
      dispatch(8'h43, 1'b1, 3'd0, 8'h00, 1'b0, 3'd5);
      check("t5_none_ready", 32'(iss_valid), 0);
      broadcast(3'd6, 8'h66);
      check("t5_e1_tag", 32'(iss_tag), 2);
      step();
      check("t5_hold_tag",   32'(iss_tag),   2);
      check("t5_hold_valid", 32'(iss_valid), 1);
      broadcast(3'd5, 8'h77);
`ifdef RS_AGE_ORDER_EN
      push(8'h66, 8'h52, 3'd2);
      push(8'h43, 8'h77, 3'd1);
`else
      push(8'h43, 8'h77, 3'd1);
      push(8'h66, 8'h52, 3'd2);
`endif
      issue_one("t5_sel0");
      issue_one("t5_sel1");
      check_empty("t5_after");

      // Asynchronous reset mid-cycle with 3 entries busy
      for (int i = 0; i < 3; i++) dispatch(8'(i + 1), 1'b1, 3'd0, 8'(i + 8), 1'b1, 3'd0);
      check("t6_count3", 32'(rs_count), 3);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_iss_valid", 32'(iss_valid), 0);
      check("t6_rst_count",     32'(rs_count),  0);
      check("t6_rst_iss_tag",   32'(iss_tag),   0);
      check("t6_rst_disp_tag",  32'(disp_tag),  1);
      step();
      rst_n = 1'b1;
      step();

      // Flush overrides dispatch and CDB capture on the same edge
      dispatch(8'h61, 1'b1, 3'd0, 8'h00, 1'b0, 3'd7);
      dispatch(8'h62, 1'b1, 3'd0, 8'h72, 1'b1, 3'd0);
      check("t7_count2", 32'(rs_count), 2);
      flush = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 8'hEE;
      dispatch(8'h63, 1'b1, 3'd0, 8'h73, 1'b1, 3'd0);
      flush = 1'b0;
      cdb_valid = 1'b0;
      check_empty("t7_flush");
      check("t7_full", 32'(rs_full), 0);
      dispatch(8'h5A, 1'b1, 3'd0, 8'hA5, 1'b1, 3'd0);
      push(8'h5A, 8'hA5, 3'd1);
      issue_one("t7_post");
      check_empty("t7_after");

      check("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/param_reservation_station.md
# param_reservation_station

Parametrised reservation station for the Tomasulo core, generalising the fixed 8-bit ADD station to configurable data width, tag width and depth. Holds dispatched instructions until both source operands are valid, snoops the common data bus (CDB) to capture pending operands, and issues ready entries to one functional unit over a valid/ready handshake. Sits between the dispatch/rename stage and a functional unit (ADD, MUL, …). Each entry owns a unique result tag that downstream logic uses for CDB broadcast.

## Interface
- DATA_W, 8, operand width
- TAG_W, 3, tag width; must hold TAG_BASE+DEPTH-1
- DEPTH, 4, entry count (2..8)
- TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept (count < DEPTH)
- disp_tag  out  TAG_W  tag allocated to the current dispatch (lowest-index free entry)
- disp_op1 / disp_op2  in  DATA_W  operand values (meaningful when Vbit=1)
- disp_op1_vbit / disp_op2_vbit  in  1  operand valid
- disp_op1_tag / disp_op2_tag  in  TAG_W  producer tag (meaningful when Vbit=0)
- cdb_valid  in  1  CDB broadcast present
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  functional unit accepts
- iss_op1 / iss_op2  out  DATA_W  operands of selected entry
- iss_tag  out  TAG_W  tag of selected entry
- rs_count  out  $clog2(DEPTH+1)  occupied entries
- rs_full  out  1  rs_count == DEPTH

## Operation
- Entry state: busy, op1/op2 value, op1/op2 Vbit, op1/op2 tag.
- Dispatch: on edge with disp_valid && disp_ready, lowest-index free entry set busy with dispatched fields. disp_tag is combinational, valid whenever disp_ready=1.
- CDB snoop: on edge with cdb_valid, every busy entry operand with Vbit=0 and tag==cdb_tag loads cdb_data, Vbit←1. Applies to both operands independently.
- Dispatch/CDB same cycle: dispatched operand with Vbit=0 and tag==cdb_tag is stored with cdb_data and Vbit=1 (no missed wakeup).
- Ready = busy && op1 Vbit && op2 Vbit. iss_valid = any ready. Selection: lowest-index ready entry (see Configuration).
- Issue: on edge with iss_valid && iss_ready, selected entry cleared (busy←0). iss_ready ignored when iss_valid=0.
- Simultaneous dispatch + issue: both occur; disp_ready reflects pre-edge count only (freed entry reusable next cycle). rs_count updates by +1, -1 or 0 accordingly.
- flush: on edge, all entries cleared; overrides dispatch, issue and CDB capture that cycle.
- iss_op1/iss_op2/iss_tag drive 0 when iss_valid=0.
- Reset (rst_n=0, any time, mid-operation included): all entries invalid immediately; disp_ready=1, disp_tag=TAG_BASE, iss_valid=0, iss_op1=iss_op2=0, iss_tag=0, rs_count=0, rs_full=0.

## Timing
- All state registered on clk rising edge; issue/dispatch outputs combinational from state.
- Dispatch with both Vbits set → iss_valid earliest next cycle (latency 1).
- CDB capture → iss_valid earliest cycle after broadcast (latency 1).
- Full: disp_ready=0 while DEPTH entries busy; dispatch attempts ignored, no state change.
- Empty: iss_valid=0; iss_ready has no effect.
- iss_valid held with iss_ready=0: selected entry and outputs stable unless an older-preference entry becomes ready (selection may change; entries never lost).

## Configuration
- RS_AGE_ORDER_EN defined: DEPTH×DEPTH age matrix tracks dispatch order; selection = oldest ready entry. Dispatch sets new entry younger than all busy entries; issue/flush clears its row/column.
- Not defined: selection = lowest-index ready entry; no age state.

## Test plan
- Reset then dispatch op1=0x12,op2=0x34 both Vbit=1 → disp_tag=1; next cycle iss_valid=1, iss_op1=0x12, iss_op2=0x34, iss_tag=1; with iss_ready=1 entry frees, rs_count 1→0.
- Dispatch op1 Vbit=0 tag=5, op2=0x07 valid; later cdb_valid tag=5 data=0xAA → next cycle iss_valid=1, iss_op1=0xAA, iss_op2=0x07.
- Dispatch op2 Vbit=0 tag=6 in same cycle as cdb_valid tag=6 data=0x3C → entry stored ready; iss_op2=0x3C next cycle.
- Four dispatches, iss_ready=0 → tags 1,2,3,4, rs_full=1, disp_ready=0; fifth dispatch ignored; issue one with dispatch same cycle → count stays 4 only after freed entry is reused next cycle.
- With RS_AGE_ORDER_EN: entry 2 ready before entry 0 (entry 0 dispatched first, woken later) → oldest ready issued first (entry 0 once ready, else entry 2); without macro → entry 0 wins whenever both ready.
- rst_n asserted low mid-cycle with 3 entries busy → iss_valid=0, rs_count=0 immediately; flush=1 with dispatch+CDB same edge → all entries empty next cycle.
